// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8N1 serial transmitter with a runtime-programmable bit period.
module uart_tx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] baud_cnt,
  input  logic        trmt,
  input  logic [7:0]  tx_data,
  output logic        TX,
  output logic        tx_done,
  output logic        busy,
  output logic        full
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t        state_q, state_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [9:0]    sh_q, sh_d;
  logic [12:0]   tmr_q, tmr_d, baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic          tx_q, tx_d, done_q, done_d;
  logic          wr, pop, bit_end, last;
  assign full    = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign busy    = state_q == SHIFT || cnt_q != '0;
  assign TX      = tx_q;
  assign tx_done = done_q;
  always_comb begin
    wr      = trmt & ~full;
    bit_end = state_q == SHIFT && tmr_q == '0;
    last    = bit_end && bit_q == 4'd9;
    pop     = cnt_q != '0 && (state_q == IDLE || last);
    state_d = state_q;
    sh_d    = sh_q;
    tmr_d   = tmr_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    if (state_q == SHIFT) begin
      tmr_d = bit_end ? baud_q : tmr_q - 13'd1;
      sh_d  = bit_end ? {1'b1, sh_q[9:1]} : sh_q;
      bit_d = bit_end ? bit_q + 4'd1 : bit_q;
      state_d = last ? IDLE : SHIFT;
    end
    // A pop overrides the end-of-frame return to IDLE, giving gapless back-to-back frames.
    if (pop) begin
      sh_d    = {1'b1, mem_q[rptr_q], 1'b0};
      tmr_d   = baud_cnt;
      baud_d  = baud_cnt;
      bit_d   = '0;
      state_d = SHIFT;
    end
    tx_d   = state_d == SHIFT ? sh_d[0] : 1'b1;
    done_d = last;
    wptr_d = wptr_q + AW'(wr);
    rptr_d = rptr_q + AW'(pop);
    cnt_d  = cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
  end
  always_ff @(posedge clk)
    if (wr) mem_q[wptr_q] <= tx_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      sh_q    <= '1;
      tmr_q   <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      tmr_q   <= tmr_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end
endmodule
